// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester word arbiter for the data memory port (option: DMEM_ARB_FIXED_PRIO_EN)
module dmem_arbiter #(
   parameter int              DW          = 32,
   parameter int              AW          = 32,
   parameter logic [AW-1:0]   PERIPH_BASE = 32'hC000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    req,
   input  logic [1:0]    we_in,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wd0,
   input  logic [DW-1:0] wd1,
   output logic [1:0]    gnt,
   output logic [1:0]    ack,
   output logic          err,
   output logic [DW-1:0] rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic          owner_q;
   logic          rej_q;
   logic [1:0]    gnt_q;
   logic [1:0]    ack_q;
   logic          err_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_a_q;
   logic [DW-1:0] mem_wd_q;
   logic [DW-1:0] rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
   logic          last_q;
`endif

   logic          win_d;
   logic          rej_d;
   logic          we_d;

   // Pick the winner among current requests and decide whether it must be rejected
   always_comb begin
      win_d = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      win_d = ~req[0];
`else
      if (req[0] && req[1]) begin
         win_d = ~last_q;
      end else begin
         win_d = req[1];
      end
`endif
      rej_d = win_d && (addr1 >= PERIPH_BASE);
      we_d  = win_d ? we_in[1] : we_in[0];
   end

   // Transaction FSM: accept in IDLE, drive memory in BUSY, acknowledge in DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= 1'b0;
         rej_q    <= 1'b0;
         gnt_q    <= 2'b00;
         ack_q    <= 2'b00;
         err_q    <= 1'b0;
         mem_we_q <= 1'b0;
         mem_a_q  <= '0;
         mem_wd_q <= '0;
         rdata_q  <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_q   <= 1'b1;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               gnt_q    <= 2'b00;
               ack_q    <= 2'b00;
               err_q    <= 1'b0;
               mem_we_q <= 1'b0;
               if (|req) begin
                  state_q  <= ST_BUSY;
                  owner_q  <= win_d;
                  rej_q    <= rej_d;
                  gnt_q    <= win_d ? 2'b10 : 2'b01;
                  mem_a_q  <= win_d ? addr1 : addr0;
                  mem_wd_q <= win_d ? wd1 : wd0;
                  // A rejected access never raises the memory write strobe
                  mem_we_q <= we_d & ~rej_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                  last_q   <= win_d;
`endif
               end
            end
            ST_BUSY: begin
               state_q  <= ST_DONE;
               gnt_q    <= 2'b00;
               mem_we_q <= 1'b0;
               rdata_q  <= rej_q ? '0 : mem_rd;
               ack_q    <= owner_q ? 2'b10 : 2'b01;
               err_q    <= rej_q;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               ack_q   <= 2'b00;
               err_q   <= 1'b0;
            end
            default: begin
               state_q  <= ST_IDLE;
               gnt_q    <= 2'b00;
               ack_q    <= 2'b00;
               err_q    <= 1'b0;
               mem_we_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt    = gnt_q;
   assign ack    = ack_q;
   assign err    = err_q;
   assign rdata  = rdata_q;
   assign mem_we = mem_we_q;
   assign mem_a  = mem_a_q;
   assign mem_wd = mem_wd_q;

endmodule
